cceip_m00_xfer_sched: RTL and testbench
=======================================

# cceip_m00_xfer_sched

Round-robin command scheduler that shares the single m00 AXI4 write master between two requesters. Typical pairing: requester 0 is the compressed-data path and requester 1 is the status/size writer. The block accepts write commands (address and byte count) and issues them one at a time to the write master's ctrl_start/addr/size interface. While a command is in flight, it routes the granted requester's AXI4-Stream into the master's s_axis port, and it returns a per-requester done pulse when the write master reports ctrl_done. It sits between the kernel-core sequencer and the AXI write master, all within ap_clk.

## Interface
Parameters:
- C_ADDR_WIDTH, 64, byte-address width of commands
- C_DATA_WIDTH, 64, stream data width
- C_XFER_SIZE_WIDTH, 64, byte-count width

Ports:
- ap_clk  in  1  kernel clock; all logic is on its rising edge
- areset  in  1  reset, synchronous, active-high
- cmd0_valid / cmd1_valid  in  1  command request
- cmd0_ready / cmd1_ready  out  1  command accepted this cycle (valid && ready)
- cmd0_addr / cmd1_addr  in  C_ADDR_WIDTH  destination byte address
- cmd0_size / cmd1_size  in  C_XFER_SIZE_WIDTH  transfer length in bytes
- cmd0_done / cmd1_done  out  1  one-cycle completion pulse
- s0_axis_tvalid / s1_axis_tvalid  in  1  requester stream valid
- s0_axis_tready / s1_axis_tready  out  1  requester stream ready
- s0_axis_tdata / s1_axis_tdata  in  C_DATA_WIDTH  requester stream data
- wm_ctrl_start  out  1  one-cycle start to the write master
- wm_ctrl_addr  out  C_ADDR_WIDTH  registered command address
- wm_ctrl_size  out  C_XFER_SIZE_WIDTH  registered command size
- wm_ctrl_done  in  1  write master completion pulse
- wm_axis_tvalid  out  1  stream to the write master
- wm_axis_tready  in  1  stream ready from the write master
- wm_axis_tdata  out  C_DATA_WIDTH  stream data to the write master
- busy  out  1  state != S_IDLE
- grant  out  1  index of the owning requester (meaningful while busy)

## Operation
- FSM states: S_IDLE, S_START, S_WAIT, S_RESP.
- S_IDLE arbitration:
  - Only one requester valid: that requester wins.
  - Both valid: the requester != last_grant wins.
  - cmdN_ready is combinational: high only in S_IDLE for the winner.
- On accept:
  - Capture addr/size into wm_ctrl_addr/wm_ctrl_size, and set grant <= N.
  - size == 0: go to S_RESP; no master start is issued.
  - Otherwise: go to S_START.
- S_START: wm_ctrl_start = 1 for exactly one cycle, then S_WAIT.
- S_WAIT stream mux:
  - wm_axis_tvalid/tdata come from s{grant}.
  - s{grant}_axis_tready = wm_axis_tready.
  - The non-granted stream's tready = 0.
  - Leave S_WAIT on wm_ctrl_done and go to S_RESP.
- Outside S_WAIT, all s*_axis_tready = 0 and wm_axis_tvalid = 0.
- S_RESP: cmd{grant}_done = 1 for one cycle; last_grant <= grant; next state is S_IDLE.
- wm_ctrl_done outside S_WAIT is ignored.
- Commands are never queued; one command is in flight at a time.

## Timing
- Accept at cycle T.
  - Non-zero size: wm_ctrl_start high at T+1.
  - Zero size: cmdN_done high at T+1.
- wm_ctrl_done at cycle D (in S_WAIT): cmdN_done at D+1. The next accept is possible at D+2.
- Minimum non-zero command occupancy: 4 cycles (S_IDLE, S_START, S_WAIT, S_RESP).
- wm_ctrl_addr/wm_ctrl_size are stable from T+1 until the next accept.
- Reset values:
  - state = S_IDLE; last_grant = 1, so requester 0 wins first contention.
  - grant = 0, busy = 0, wm_ctrl_start = 0, cmd*_done = 0, cmd*_ready = 0.
  - wm_ctrl_addr = 0, wm_ctrl_size = 0, all tready/tvalid = 0.
- Reset mid-operation:
  - Abandons the in-flight command; no done pulse is issued.
  - The external write master must be reset by the same areset.
- Requester valid deasserting before acceptance: no accept. This is permitted, but it is not AXI-compliant usage.

## Configuration
- CCEIP_XFER_SCHED_STATS_EN defined:
  - Adds outputs stat_cmd_cnt0/stat_cmd_cnt1 (32 b) and stat_byte_cnt0/stat_byte_cnt1 (64 b).
  - On each S_RESP, increment the granted requester's command count by 1 and its byte count by the captured size. Zero-size commands count as commands and add 0 bytes.
  - Counters wrap modulo 2^width and reset to 0 on areset.
- Not defined: these ports and registers are absent; all other behaviour is identical.

## Test plan
- Single command: cmd0 addr=0x1000, size=64, eight beats on s0 → wm_ctrl_start at T+1 with addr 0x1000/size 64; eight beats appear on wm_axis; cmd0_done one cycle after wm_ctrl_done.
- Contention: cmd0 and cmd1 valid together for three rounds after reset → grant order 0,1,0; s1 tready stays 0 while grant = 0.
- Zero size: cmd1 size=0 → cmd1_done at T+1; wm_ctrl_start never asserted.
- Backpressure: wm_axis_tready toggled 1/0 during a 16-beat transfer → data is passed in order with no loss or duplication, and s0 tready mirrors wm_axis_tready.
- Reset in S_WAIT: areset mid-transfer → all outputs at reset values next cycle; no done pulse; a subsequent cmd0 is accepted normally.
- Stats (macro on): cmd0 sizes 64 and 8, cmd1 size 0 → stat_cmd_cnt0 = 2, stat_byte_cnt0 = 72, stat_cmd_cnt1 = 1, stat_byte_cnt1 = 0.

Source files
------------

// File: rtl/cceip_m00_xfer_sched.sv
// Round-robin scheduler sharing the m00 AXI4 write master between two command/stream requesters.
// Optional per-requester statistics counters are enabled with CCEIP_XFER_SCHED_STATS_EN.
module cceip_m00_xfer_sched #(
    parameter int C_ADDR_WIDTH      = 64,
    parameter int C_DATA_WIDTH      = 64,
    parameter int C_XFER_SIZE_WIDTH = 64
) (
    input  logic                         ap_clk,
    input  logic                         areset,
    input  logic                         cmd0_valid,
    output logic                         cmd0_ready,
    input  logic [C_ADDR_WIDTH-1:0]      cmd0_addr,
    input  logic [C_XFER_SIZE_WIDTH-1:0] cmd0_size,
    output logic                         cmd0_done,
    input  logic                         cmd1_valid,
    output logic                         cmd1_ready,
    input  logic [C_ADDR_WIDTH-1:0]      cmd1_addr,
    input  logic [C_XFER_SIZE_WIDTH-1:0] cmd1_size,
    output logic                         cmd1_done,
    input  logic                         s0_axis_tvalid,
    output logic                         s0_axis_tready,
    input  logic [C_DATA_WIDTH-1:0]      s0_axis_tdata,
    input  logic                         s1_axis_tvalid,
    output logic                         s1_axis_tready,
    input  logic [C_DATA_WIDTH-1:0]      s1_axis_tdata,
    output logic                         wm_ctrl_start,
    output logic [C_ADDR_WIDTH-1:0]      wm_ctrl_addr,
    output logic [C_XFER_SIZE_WIDTH-1:0] wm_ctrl_size,
    input  logic                         wm_ctrl_done,
    output logic                         wm_axis_tvalid,
    input  logic                         wm_axis_tready,
    output logic [C_DATA_WIDTH-1:0]      wm_axis_tdata,
    output logic                         busy,
    output logic                         grant
`ifdef CCEIP_XFER_SCHED_STATS_EN
    ,
    output logic [31:0]                  stat_cmd_cnt0,
    output logic [31:0]                  stat_cmd_cnt1,
    output logic [63:0]                  stat_byte_cnt0,
    output logic [63:0]                  stat_byte_cnt1
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

    state_t                       state;
    logic                         last_grant;
    logic                         win1;
    logic                         accept;
    logic                         in_wait;
    logic [C_ADDR_WIDTH-1:0]      sel_addr;
    logic [C_XFER_SIZE_WIDTH-1:0] sel_size;

    // Requester 1 wins when it is alone, or when both ask and requester 0 went last.
    assign win1     = cmd1_valid && (!cmd0_valid || !last_grant);
    assign accept   = (state == S_IDLE) && (cmd0_valid || cmd1_valid);
    assign sel_addr = win1 ? cmd1_addr : cmd0_addr;
    assign sel_size = win1 ? cmd1_size : cmd0_size;

    assign cmd0_ready = accept && !win1;
    assign cmd1_ready = accept && win1;

    assign in_wait        = (state == S_WAIT);
    assign wm_axis_tvalid = in_wait && (grant ? s1_axis_tvalid : s0_axis_tvalid);
    assign wm_axis_tdata  = grant ? s1_axis_tdata : s0_axis_tdata;
    assign s0_axis_tready = in_wait && !grant && wm_axis_tready;
    assign s1_axis_tready = in_wait && grant && wm_axis_tready;
    assign busy           = (state != S_IDLE);

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            state          <= S_IDLE;
            last_grant     <= 1'b1;
            grant          <= 1'b0;
            wm_ctrl_start  <= 1'b0;
            wm_ctrl_addr   <= '0;
            wm_ctrl_size   <= '0;
            cmd0_done      <= 1'b0;
            cmd1_done      <= 1'b0;
`ifdef CCEIP_XFER_SCHED_STATS_EN
            stat_cmd_cnt0  <= '0;
            stat_cmd_cnt1  <= '0;
            stat_byte_cnt0 <= '0;
            stat_byte_cnt1 <= '0;
`endif
        end else begin
            wm_ctrl_start <= 1'b0;
            cmd0_done     <= 1'b0;
            cmd1_done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        grant        <= win1;
                        wm_ctrl_addr <= sel_addr;
                        wm_ctrl_size <= sel_size;
                        // Zero-length commands never touch the master; complete directly.
                        if (sel_size == '0) begin
                            state     <= S_RESP;
                            cmd0_done <= !win1;
                            cmd1_done <= win1;
                        end else begin
                            state         <= S_START;
                            wm_ctrl_start <= 1'b1;
                        end
                    end
                end
                S_START: state <= S_WAIT;
                S_WAIT: begin
                    if (wm_ctrl_done) begin
                        state     <= S_RESP;
                        cmd0_done <= !grant;
                        cmd1_done <= grant;
                    end
                end
                S_RESP: begin
                    last_grant <= grant;
                    state      <= S_IDLE;
`ifdef CCEIP_XFER_SCHED_STATS_EN
                    if (grant) begin
                        stat_cmd_cnt1  <= stat_cmd_cnt1 + 32'd1;
                        stat_byte_cnt1 <= stat_byte_cnt1 + 64'(wm_ctrl_size);
                    end else begin
                        stat_cmd_cnt0  <= stat_cmd_cnt0 + 32'd1;
                        stat_byte_cnt0 <= stat_byte_cnt0 + 64'(wm_ctrl_size);
                    end
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cceip_m00_xfer_sched.sv
// Randomized bench for cceip_m00_xfer_sched against a transaction-timeline reference model.
module tb_cceip_m00_xfer_sched;

    logic        ap_clk = 1'b0;
    logic        areset;
    logic        cmd0_valid, cmd0_ready, cmd0_done;
    logic        cmd1_valid, cmd1_ready, cmd1_done;
    logic [63:0] cmd0_addr, cmd0_size, cmd1_addr, cmd1_size;
    logic        s0_axis_tvalid, s0_axis_tready, s1_axis_tvalid, s1_axis_tready;
    logic [63:0] s0_axis_tdata, s1_axis_tdata;
    logic        wm_ctrl_start, wm_ctrl_done;
    logic [63:0] wm_ctrl_addr, wm_ctrl_size;
    logic        wm_axis_tvalid, wm_axis_tready;
    logic [63:0] wm_axis_tdata;
    logic        busy, grant;
`ifdef CCEIP_XFER_SCHED_STATS_EN
    logic [31:0] stat_cmd_cnt0, stat_cmd_cnt1;
    logic [63:0] stat_byte_cnt0, stat_byte_cnt1;
`endif

    cceip_m00_xfer_sched dut (
        .ap_clk(ap_clk), .areset(areset),
        .cmd0_valid(cmd0_valid), .cmd0_ready(cmd0_ready), .cmd0_addr(cmd0_addr),
        .cmd0_size(cmd0_size), .cmd0_done(cmd0_done),
        .cmd1_valid(cmd1_valid), .cmd1_ready(cmd1_ready), .cmd1_addr(cmd1_addr),
        .cmd1_size(cmd1_size), .cmd1_done(cmd1_done),
        .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tready(s0_axis_tready), .s0_axis_tdata(s0_axis_tdata),
        .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tready(s1_axis_tready), .s1_axis_tdata(s1_axis_tdata),
        .wm_ctrl_start(wm_ctrl_start), .wm_ctrl_addr(wm_ctrl_addr), .wm_ctrl_size(wm_ctrl_size),
        .wm_ctrl_done(wm_ctrl_done),
        .wm_axis_tvalid(wm_axis_tvalid), .wm_axis_tready(wm_axis_tready), .wm_axis_tdata(wm_axis_tdata),
        .busy(busy), .grant(grant)
`ifdef CCEIP_XFER_SCHED_STATS_EN
        , .stat_cmd_cnt0(stat_cmd_cnt0), .stat_cmd_cnt1(stat_cmd_cnt1),
        .stat_byte_cnt0(stat_byte_cnt0), .stat_byte_cnt1(stat_byte_cnt1)
`endif
    );

    always #5 ap_clk = ~ap_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: one command owns the master from accept+1 through its done cycle.
    int          owner, last, acc, dcyc, resp, need, beats, w;
    bit          zero, post_rst, rst_once, window, do_rst, idle, anyv;
    bit          pend[2];
    logic [63:0] p_addr[2], p_size[2];
    int          scnt[2];
    logic [63:0] cap_addr, cap_size;
    logic [31:0] m_cmd[2];
    logic [63:0] m_byte[2];
    bit          e_rdy0, e_rdy1, e_start, e_done0, e_done1, e_tr0, e_tr1, e_wv, sv0, sv1;

    initial begin
        areset = 1'b1;
        {cmd0_valid, cmd1_valid, s0_axis_tvalid, s1_axis_tvalid, wm_ctrl_done, wm_axis_tready} = '0;
        {cmd0_addr, cmd0_size, cmd1_addr, cmd1_size, s0_axis_tdata, s1_axis_tdata} = '0;
        owner = -1; last = 1; acc = 0; dcyc = -1; resp = -1; need = 0; beats = 0; zero = 0;
        post_rst = 1; rst_once = 0; cap_addr = '0; cap_size = '0;
        for (int r = 0; r < 2; r++) begin
            pend[r] = 1; p_addr[r] = {$urandom, $urandom}; p_size[r] = 64'(8 * $urandom_range(1, 16));
            scnt[r] = 0; m_cmd[r] = '0; m_byte[r] = '0;
        end
        repeat (3) @(posedge ap_clk);

        for (int c = 0; c < 4000; c++) begin
            @(negedge ap_clk);
            if (owner >= 0 && resp >= 0 && c == resp + 1) begin
                last = owner; owner = -1;
            end
            if (owner >= 0 && c - acc > 2000) begin
                chk("hang", 64'(c - acc), 64'd0);
                break;
            end
            for (int r = 0; r < 2; r++)
                if (!pend[r] && $urandom_range(0, 3) == 0) begin
                    pend[r]   = 1;
                    p_addr[r] = {$urandom, $urandom};
                    p_size[r] = ($urandom_range(0, 4) == 0) ? 64'd0 : 64'(8 * $urandom_range(1, 16));
                end
            window = owner >= 0 && !zero && c >= acc + 2 && dcyc < 0;
            do_rst = window && ((!rst_once && c > 2000) || $urandom_range(0, 299) == 0);

            areset         = do_rst;
            cmd0_valid     = !post_rst && pend[0];
            cmd1_valid     = !post_rst && pend[1];
            cmd0_addr      = p_addr[0]; cmd0_size = p_size[0];
            cmd1_addr      = p_addr[1]; cmd1_size = p_size[1];
            sv0            = $urandom_range(0, 3) != 0;
            sv1            = $urandom_range(0, 3) != 0;
            s0_axis_tvalid = sv0;
            s1_axis_tvalid = sv1;
            s0_axis_tdata  = {32'd0, 32'(scnt[0])};
            s1_axis_tdata  = {32'd1, 32'(scnt[1])};
            wm_axis_tready = (c >= 300 && c < 700) ? (c % 2 == 1) : ($urandom_range(0, 2) != 0);
            if (do_rst)      wm_ctrl_done = 1'b0;
            else if (window) wm_ctrl_done = (beats >= need) && ($urandom_range(0, 2) == 0);
            else             wm_ctrl_done = ($urandom_range(0, 9) == 0);
            #1;

            idle    = owner < 0;
            anyv    = cmd0_valid || cmd1_valid;
            w       = (cmd0_valid && cmd1_valid) ? (1 - last) : (cmd1_valid ? 1 : 0);
            e_rdy0  = idle && anyv && w == 0;
            e_rdy1  = idle && anyv && w == 1;
            e_start = owner >= 0 && !zero && c == acc + 1;
            e_done0 = owner == 0 && resp >= 0 && c == resp;
            e_done1 = owner == 1 && resp >= 0 && c == resp;
            e_tr0   = window && owner == 0 && wm_axis_tready;
            e_tr1   = window && owner == 1 && wm_axis_tready;
            e_wv    = window && ((owner == 0) ? sv0 : sv1);

            chk("cmd0_ready", 64'(cmd0_ready), 64'(e_rdy0));
            chk("cmd1_ready", 64'(cmd1_ready), 64'(e_rdy1));
            chk("wm_ctrl_start", 64'(wm_ctrl_start), 64'(e_start));
            chk("cmd0_done", 64'(cmd0_done), 64'(e_done0));
            chk("cmd1_done", 64'(cmd1_done), 64'(e_done1));
            chk("busy", 64'(busy), 64'(!idle));
            chk("s0_tready", 64'(s0_axis_tready), 64'(e_tr0));
            chk("s1_tready", 64'(s1_axis_tready), 64'(e_tr1));
            chk("wm_tvalid", 64'(wm_axis_tvalid), 64'(e_wv));
            chk("wm_ctrl_addr", wm_ctrl_addr, cap_addr);
            chk("wm_ctrl_size", wm_ctrl_size, cap_size);
            if (e_wv)
                chk("wm_tdata", wm_axis_tdata, {32'(owner), 32'(scnt[owner])});
            if (post_rst)
                chk("grant_rst", 64'(grant), 64'd0);
            else if (!idle)
                chk("grant", 64'(grant), 64'(owner));

            if (e_done0 || e_done1) begin
                m_cmd[owner]  = m_cmd[owner] + 32'd1;
                m_byte[owner] = m_byte[owner] + cap_size;
            end
            if (window && wm_axis_tready && e_wv) begin
                scnt[owner]++;
                beats++;
            end
            if (window && wm_ctrl_done) begin
                dcyc = c; resp = c + 1;
            end
            if (e_rdy0 || e_rdy1) begin
                owner = w; acc = c; pend[w] = 0;
                cap_addr = p_addr[w]; cap_size = p_size[w];
                zero = (p_size[w] == 64'd0);
                dcyc = -1; resp = zero ? c + 1 : -1;
                need = int'((p_size[w] + 64'd7) / 64'd8); beats = 0;
            end
            post_rst = 0;
            if (do_rst) begin
                owner = -1; last = 1; cap_addr = '0; cap_size = '0;
                dcyc = -1; resp = -1; beats = 0; zero = 0;
                m_cmd[0] = '0; m_cmd[1] = '0; m_byte[0] = '0; m_byte[1] = '0;
                post_rst = 1; rst_once = 1;
            end
        end

        @(negedge ap_clk);
        areset = 1'b0;
        chk("reset_exercised", 64'(rst_once), 64'd1);
`ifdef CCEIP_XFER_SCHED_STATS_EN
        // Let any in-flight response retire before sampling the counters.
        cmd0_valid = 1'b0; cmd1_valid = 1'b0; wm_ctrl_done = 1'b0;
        if (owner >= 0 && resp < 0) begin
            @(negedge ap_clk) wm_ctrl_done = 1'b1;
            @(negedge ap_clk) wm_ctrl_done = 1'b0;
            m_cmd[owner]  = m_cmd[owner] + 32'd1;
            m_byte[owner] = m_byte[owner] + cap_size;
        end
        repeat (4) @(negedge ap_clk);
        chk("stat_cmd_cnt0", 64'(stat_cmd_cnt0), 64'(m_cmd[0]));
        chk("stat_cmd_cnt1", 64'(stat_cmd_cnt1), 64'(m_cmd[1]));
        chk("stat_byte_cnt0", stat_byte_cnt0, m_byte[0]);
        chk("stat_byte_cnt1", stat_byte_cnt1, m_byte[1]);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
